// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: command codes, datapath widths and FSM states.
// Imported by the interface, the ALU, the round-robin picker and the arbiter top.
package alu_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_ADD = 3'b000;
  localparam logic [CMD_W-1:0] CMD_SUB = 3'b001;
  localparam logic [CMD_W-1:0] CMD_AND = 3'b010;
  localparam logic [CMD_W-1:0] CMD_OR  = 3'b011;
  localparam logic [CMD_W-1:0] CMD_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Legal commands are CMD_ADD..CMD_NOT; any higher code is reported as an error.
  function automatic logic cmd_legal(input logic [CMD_W-1:0] cmd);
    return cmd <= CMD_NOT;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU-side and response signals around the shared ALU arbiter.
// Request: a transfer happens on a clock edge only when req_valid[i] & req_ready[i];
// response: rsp_* are held stable from rsp_valid rising until the edge with rsp_valid & rsp_ready.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();
  import alu_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [OP_W*NUM_REQ-1:0]   req_a;
  logic [OP_W*NUM_REQ-1:0]   req_b;
  logic [CMD_W*NUM_REQ-1:0]  req_cmd;

  logic [OP_W-1:0]           alu_a_out;
  logic [OP_W-1:0]           alu_b_out;
  logic [CMD_W-1:0]          alu_cmd_out;
  logic                      alu_en_out;
  logic [RES_W-1:0]          alu_d_in;

  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [RES_W-1:0]          rsp_data;
  logic                      rsp_err;
  logic                      rsp_ready;

  state_t                    dbg_state;

  modport slave (
    input  req_valid, req_a, req_b, req_cmd, alu_d_in, rsp_ready,
    output req_ready, alu_a_out, alu_b_out, alu_cmd_out, alu_en_out,
    output rsp_valid, rsp_id, rsp_data, rsp_err, dbg_state
  );

  modport master (
    output req_valid, req_a, req_b, req_cmd, alu_d_in, rsp_ready,
    input  req_ready, alu_a_out, alu_b_out, alu_cmd_out, alu_en_out,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, dbg_state
  );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU with a 16-bit result; output is zero when not enabled.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic             en_i,
  output logic [RES_W-1:0] d_o
);

  always_comb begin
    d_o = '0;
    if (en_i) begin
      case (cmd_i)
        CMD_ADD: d_o = {8'h00, a_i} + {8'h00, b_i};
        CMD_SUB: d_o = {8'h00, a_i} - {8'h00, b_i};
        CMD_AND: d_o = {8'h00, a_i & b_i};
        CMD_OR:  d_o = {8'h00, a_i | b_i};
        CMD_NOT: d_o = {8'h00, ~a_i};
        default: d_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic            found;
  logic [ID_W-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin accept,
// one ISSUE cycle driving the ALU, then a held response until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [OP_W-1:0]       a_q, b_q;
  logic [CMD_W-1:0]      cmd_q;
  logic [ID_W-1:0]       id_q;
  logic [RES_W-1:0]      data_q;
  logic                  err_q;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  any_req;
  logic [OP_W-1:0]       sel_a, sel_b;
  logic [CMD_W-1:0]      sel_cmd;
  logic                  accept, capture, release_rsp;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_req)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a   = bus.req_a[OP_W*i +: OP_W];
        sel_b   = bus.req_b[OP_W*i +: OP_W];
        sel_cmd = bus.req_cmd[CMD_W*i +: CMD_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          release_rsp = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer moves past the winner only once its response has been taken.
  always_comb begin
    ptr_d = ptr_q;
    if (release_rsp) begin
      ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        cmd_q <= sel_cmd;
        id_q  <= grant_idx;
      end
      if (capture) begin
        data_q <= cmd_legal(cmd_q) ? bus.alu_d_in : '0;
        err_q  <= !cmd_legal(cmd_q);
      end
    end
  end

  // Gated by rst_n so no accept strobe is visible while reset is held.
  assign bus.req_ready   = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign bus.alu_a_out   = a_q;
  assign bus.alu_b_out   = b_q;
  assign bus.alu_cmd_out = cmd_q;
  assign bus.alu_en_out  = (state_q == ST_ISSUE) && cmd_legal(cmd_q);
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = data_q;
  assign bus.rsp_err     = err_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with the combinational ALU attached.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter_if #(.NUM_REQ(4)) bus ();

  alu_arbiter #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu u_alu (
    .a_i   (bus.alu_a_out),
    .b_i   (bus.alu_b_out),
    .cmd_i (bus.alu_cmd_out),
    .en_i  (bus.alu_en_out),
    .d_o   (bus.alu_d_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] cmd);
    bus.req_a[8*i +: 8]   = a;
    bus.req_b[8*i +: 8]   = b;
    bus.req_cmd[3*i +: 3] = cmd;
    bus.req_valid[i]      = 1'b1;
  endtask

  task automatic drop_req(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cmd   = '0;
    bus.rsp_ready = 1'b0;
    tick();
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if (bus.alu_en_out !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en: got %b expected 0", bus.alu_en_out); end
    n_checks++; if (bus.alu_a_out !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a: got %0d expected 0", bus.alu_a_out); end
    n_checks++; if (bus.rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_data: got %0d expected 0", bus.rsp_data); end
    n_checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_err_id: got err=%b id=%0d expected 0/0", bus.rsp_err, bus.rsp_id); end
    n_checks++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", bus.dbg_state); end
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_req(0, 8'd12, 8'd10, CMD_ADD);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
    tick();
    drop_req(0);
    n_checks++; if (bus.alu_en_out !== 1'b1 || bus.alu_a_out !== 8'd12 || bus.alu_b_out !== 8'd10) begin n_fail++; $display("FAIL single_issue: got en=%b a=%0d b=%0d expected 1/12/10", bus.alu_en_out, bus.alu_a_out, bus.alu_b_out); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp: got %b expected 0", bus.rsp_valid); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp: got valid=%b id=%0d expected 1/0", bus.rsp_valid, bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 16'd22 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_data: got %0d err=%b expected 22/0", bus.rsp_data, bus.rsp_err); end
    n_checks++; if (bus.alu_en_out !== 1'b0) begin n_fail++; $display("FAIL single_en_resp: got %b expected 0", bus.alu_en_out); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.alu_a_out !== 8'd12) begin n_fail++; $display("FAIL single_idle: got valid=%b a=%0d expected 0/12", bus.rsp_valid, bus.alu_a_out); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_data [4];
    logic [3:0]  exp_rdy;
    exp_data[0] = 16'd5;
    exp_data[1] = 16'd2;
    exp_data[2] = 16'd13;
    exp_data[3] = 16'd250;
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 8'd15, 8'd10, CMD_SUB);
    set_req(1, 8'd2,  8'd3,  CMD_AND);
    set_req(2, 8'd4,  8'd9,  CMD_OR);
    set_req(3, 8'd5,  8'd0,  CMD_NOT);
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = 4'b0001 << k;
      n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_ready%0d: got %b expected %b", k, bus.req_ready, exp_rdy); end
      tick();
      drop_req(k);
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k)) begin n_fail++; $display("FAIL contention_id%0d: got valid=%b id=%0d expected 1/%0d", k, bus.rsp_valid, bus.rsp_id, k); end
      n_checks++; if (bus.rsp_data !== exp_data[k]) begin n_fail++; $display("FAIL contention_data%0d: got %0d expected %0d", k, bus.rsp_data, exp_data[k]); end
      tick();
    end
    bus.req_valid = 4'b0101;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL contention_wrap: got %b expected 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    set_req(0, 8'd7, 8'd1, CMD_ADD);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 0001", bus.req_ready); end
    tick();
    drop_req(0);
    set_req(1, 8'd20, 8'd6, CMD_SUB);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_issue_ready: got %b expected 0000", bus.req_ready); end
    tick();
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'd8 || bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold%0d: got valid=%b data=%0d id=%0d expected 1/8/0", c, bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 0000", c, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0000", bus.req_ready); end
    tick();
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_ready: got %b expected 0010", bus.req_ready); end
    tick();
    drop_req(1);
    tick();
    n_checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 16'd14) begin n_fail++; $display("FAIL bp_second_rsp: got id=%0d data=%0d expected 1/14", bus.rsp_id, bus.rsp_data); end
    tick();
  endtask

  task automatic test_illegal();
    set_req(2, 8'd9, 8'd9, 3'b110);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL illegal_ready: got %b expected 0100", bus.req_ready); end
    tick();
    drop_req(2);
    n_checks++; if (bus.alu_en_out !== 1'b0 || bus.dbg_state !== ST_ISSUE) begin n_fail++; $display("FAIL illegal_en: got en=%b state=%0d expected 0/ISSUE", bus.alu_en_out, bus.dbg_state); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL illegal_err: got valid=%b err=%b id=%0d expected 1/1/2", bus.rsp_valid, bus.rsp_err, bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 16'd0 || bus.alu_en_out !== 1'b0) begin n_fail++; $display("FAIL illegal_data: got data=%0d en=%b expected 0/0", bus.rsp_data, bus.alu_en_out); end
    tick();
  endtask

  task automatic test_wrap();
    set_req(3, 8'd3, 8'd10, CMD_SUB);
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready: got %b expected 1000", bus.req_ready); end
    tick();
    drop_req(3);
    tick();
    n_checks++; if (bus.rsp_data !== 16'hFFF9 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wrap_sub: got %h err=%b expected fff9/0", bus.rsp_data, bus.rsp_err); end
    tick();
    set_req(0, 8'd255, 8'd255, CMD_ADD);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b expected 0001", bus.req_ready); end
    tick();
    drop_req(0);
    tick();
    n_checks++; if (bus.rsp_data !== 16'd510) begin n_fail++; $display("FAIL wrap_add: got %0d expected 510", bus.rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2, 8'd6, 8'd7, CMD_ADD);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rmid_ready: got %b expected 0100", bus.req_ready); end
    tick();
    n_checks++; if (bus.alu_en_out !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: got %b expected 1", bus.alu_en_out); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.alu_en_out !== 1'b0 || bus.alu_a_out !== 8'd0 || bus.alu_b_out !== 8'd0) begin n_fail++; $display("FAIL rmid_alu: got en=%b a=%0d b=%0d expected 0/0/0", bus.alu_en_out, bus.alu_a_out, bus.alu_b_out); end
    n_checks++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'd0) begin n_fail++; $display("FAIL rmid_outs: got ready=%b valid=%b data=%0d expected 0000/0/0", bus.req_ready, bus.rsp_valid, bus.rsp_data); end
    drop_req(2);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rsp%0d: got %b expected 0", c, bus.rsp_valid); end
    end
    set_req(0, 8'd1, 8'd1, CMD_ADD);
    set_req(1, 8'd1, 8'd2, CMD_ADD);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr: got %b expected 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    #1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
